// File: rtl/hex_display_scanner_pkg.sv
// hex_disp_pkg: shared types and helpers for the multiplexed hex display scanner.
package hex_disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIBBLE_W   = 4;
    localparam int VALUE_W    = NUM_DIGITS * NIBBLE_W;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {BLANK, DRIVE} scan_state_t;

    typedef struct packed {
        logic [VALUE_W-1:0]    value;
        logic [NUM_DIGITS-1:0] mask;
    } disp_buf_t;

    // A digit is dark when masked, or when it and every digit left of it are zero.
    // Digit 0 is exempt from zero suppression so a zero value still shows "0".
    function automatic logic digit_suppressed(
        input digit_idx_t            k,
        input logic [VALUE_W-1:0]    v,
        input logic [NUM_DIGITS-1:0] m,
        input logic                  lz
    );
        logic [VALUE_W-1:0] upper;
        upper = v >> {k, 2'b00};
        return m[k] | (lz & (k != 2'd0) & (upper == '0));
    endfunction

endpackage

// File: rtl/hex_display_scanner_slot_timer.sv
// slot_timer: free-running per-digit slot counter with end-of-blank and end-of-slot strobes.
module slot_timer #(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic blank_end,
    output logic slot_end,
    output logic pre_end
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= slot_end ? '0 : cnt + 1'b1;
    end

    assign slot_end  = cnt == CW'(TICK_DIV - 1);
    assign pre_end   = cnt == CW'(TICK_DIV - 2);
    assign blank_end = (BLANK_CYCLES > 0) && (cnt == CW'(BLANK_CYCLES - 1));

endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: scans a double-buffered 16-bit value onto a 4-digit
// 7-segment decoder with anti-ghost blanking, masking and leading-zero suppression.
module hex_display_scanner
    import hex_disp_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [VALUE_W-1:0]    value_in,
    input  logic [NUM_DIGITS-1:0] mask_in,
    input  logic                  lz_blank,
    output logic [NUM_DIGITS-1:0] en_bus,
    output logic [NIBBLE_W-1:0]   bin_out,
    output logic                  frame_done
);

    localparam scan_state_t SLOT_START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    logic        blank_end, slot_end, pre_end;
    digit_idx_t  digit, nxt_digit;
    scan_state_t state, nxt_state;
    disp_buf_t   shadow, active, nxt_active, in_buf;

    slot_timer #(
        .TICK_DIV    (TICK_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .blank_end(blank_end),
        .slot_end (slot_end),
        .pre_end  (pre_end)
    );

    assign in_buf     = {value_in, mask_in};
    assign nxt_digit  = slot_end ? digit + 1'b1 : digit;
    assign nxt_state  = slot_end ? SLOT_START : (blank_end ? DRIVE : state);
    // frame_done is high during the last frame cycle, so its edge is the swap point;
    // a load on that same edge goes straight to the active buffer.
    assign nxt_active = frame_done ? (load ? in_buf : shadow) : active;

    // Outputs are registered from next-cycle state so they line up with the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit      <= '0;
            state      <= SLOT_START;
            shadow     <= '0;
            active     <= '0;
            en_bus     <= '0;
            bin_out    <= '0;
            frame_done <= 1'b0;
        end else begin
            digit      <= nxt_digit;
            state      <= nxt_state;
            active     <= nxt_active;
            shadow     <= load ? in_buf : shadow;
            bin_out    <= nxt_active.value[{nxt_digit, 2'b00} +: NIBBLE_W];
            en_bus     <= (nxt_state == DRIVE &&
                           !digit_suppressed(nxt_digit, nxt_active.value, nxt_active.mask, lz_blank))
                          ? NUM_DIGITS'(1) << nxt_digit : '0;
            frame_done <= pre_end && (digit == 2'd3);
        end
    end

endmodule
